// File: rtl/std_mshr_file_if.sv
// Bus bundle between the cache controller, the memory request/refill path and std_mshr_file.
interface std_mshr_file_if #(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned IDX_WIDTH  = 2
);
    logic                  alloc_valid_i;
    logic                  alloc_ready_o;
    logic [ID_WIDTH-1:0]   alloc_id_i;
    logic [ADDR_WIDTH-1:0] alloc_addr_i;
    logic                  alloc_we_i;
    logic [63:0]           alloc_wdata_i;
    logic [7:0]            alloc_be_i;
    logic [IDX_WIDTH-1:0]  alloc_idx_o;
    logic [ADDR_WIDTH-1:0] lookup_addr_i;
    logic                  lookup_hit_o;
    logic [IDX_WIDTH-1:0]  lookup_idx_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [ADDR_WIDTH-1:0] mem_req_addr_o;
    logic [IDX_WIDTH-1:0]  mem_req_idx_o;
    logic                  fill_valid_i;
    logic [IDX_WIDTH-1:0]  fill_idx_i;
    logic                  retire_valid_o;
    logic                  retire_ready_i;
    logic [IDX_WIDTH-1:0]  retire_idx_o;
    logic [ID_WIDTH-1:0]   retire_id_o;
    logic [ADDR_WIDTH-1:0] retire_addr_o;
    logic                  retire_we_o;
    logic [63:0]           retire_wdata_o;
    logic [7:0]            retire_be_o;
    logic                  full_o;
    logic                  busy_o;

    modport slave (
        input  alloc_valid_i, alloc_id_i, alloc_addr_i, alloc_we_i, alloc_wdata_i, alloc_be_i,
        input  lookup_addr_i, mem_req_ready_i, fill_valid_i, fill_idx_i, retire_ready_i,
        output alloc_ready_o, alloc_idx_o, lookup_hit_o, lookup_idx_o,
        output mem_req_valid_o, mem_req_addr_o, mem_req_idx_o,
        output retire_valid_o, retire_idx_o, retire_id_o, retire_addr_o, retire_we_o,
        output retire_wdata_o, retire_be_o, full_o, busy_o
    );

    modport master (
        output alloc_valid_i, alloc_id_i, alloc_addr_i, alloc_we_i, alloc_wdata_i, alloc_be_i,
        output lookup_addr_i, mem_req_ready_i, fill_valid_i, fill_idx_i, retire_ready_i,
        input  alloc_ready_o, alloc_idx_o, lookup_hit_o, lookup_idx_o,
        input  mem_req_valid_o, mem_req_addr_o, mem_req_idx_o,
        input  retire_valid_o, retire_idx_o, retire_id_o, retire_addr_o, retire_we_o,
        input  retire_wdata_o, retire_be_o, full_o, busy_o
    );
endinterface

// File: rtl/std_mshr_file.sv
// Multi-entry miss-status holding register file: FREE -> PENDING -> INFLIGHT -> DONE per entry.
// Optional store merging into PENDING entries is enabled with `define STD_CACHE_MSHR_MERGE_EN.
module std_mshr_file #(
    parameter int unsigned NR_ENTRIES  = 4,
    parameter int unsigned ADDR_WIDTH  = 56,
    parameter int unsigned ID_WIDTH    = 2,
    parameter int unsigned LINE_OFFSET = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    std_mshr_file_if.slave bus
);
    localparam int unsigned IDX_WIDTH = $clog2(NR_ENTRIES);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        INFLIGHT = 2'd2,
        DONE     = 2'd3
    } ent_state_e;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [63:0]           wdata;
        logic [7:0]            be;
    } ent_t;

    ent_state_e state_q [NR_ENTRIES];
    ent_state_e state_d [NR_ENTRIES];
    ent_t       ent_q   [NR_ENTRIES];
    ent_t       ent_d   [NR_ENTRIES];

    logic                 free_found, busy, line_hit, merge_hit, pend_found, done_found, lookup_hit;
    logic [IDX_WIDTH-1:0] free_idx, pend_idx, done_idx, merge_idx, lookup_idx;
    logic                 mem_hold_q, mem_hold_d, ret_hold_q, ret_hold_d;
    logic [IDX_WIDTH-1:0] mem_hold_idx_q, mem_hold_idx_d, ret_hold_idx_q, ret_hold_idx_d;
    logic                 alloc_ready, alloc_fire, mem_valid, mem_fire, ret_valid, ret_fire;
    logic [IDX_WIDTH-1:0] alloc_idx, mem_idx, ret_idx;
    logic                 unused_lookup_offset;

    // Priority scan over registered entry state: lowest FREE/PENDING/DONE and line matches.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        busy       = 1'b0;
        line_hit   = 1'b0;
        pend_found = 1'b0;
        pend_idx   = '0;
        done_found = 1'b0;
        done_idx   = '0;
        lookup_hit = 1'b0;
        lookup_idx = '0;
        merge_hit  = 1'b0;
        merge_idx  = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (state_q[i] == FREE) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_WIDTH'(i);
                end
            end else begin
                busy = 1'b1;
                if (ent_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == bus.alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET])
                    line_hit = 1'b1;
                if (!lookup_hit &&
                    ent_q[i].addr[ADDR_WIDTH-1:LINE_OFFSET] == bus.lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET]) begin
                    lookup_hit = 1'b1;
                    lookup_idx = IDX_WIDTH'(i);
                end
            end
            if (state_q[i] == PENDING && !pend_found) begin
                pend_found = 1'b1;
                pend_idx   = IDX_WIDTH'(i);
            end
            if (state_q[i] == DONE && !done_found) begin
                done_found = 1'b1;
                done_idx   = IDX_WIDTH'(i);
            end
`ifdef STD_CACHE_MSHR_MERGE_EN
            if (!merge_hit && bus.alloc_we_i && state_q[i] == PENDING && ent_q[i].we &&
                ent_q[i].addr[ADDR_WIDTH-1:3] == bus.alloc_addr_i[ADDR_WIDTH-1:3]) begin
                merge_hit = 1'b1;
                merge_idx = IDX_WIDTH'(i);
            end
`endif
        end
    end

    // A presented request/retire is locked to its entry until the handshake completes.
    assign alloc_ready = merge_hit || (free_found && !line_hit);
    assign alloc_idx   = merge_hit ? merge_idx : free_idx;
    assign alloc_fire  = bus.alloc_valid_i && alloc_ready;
    assign mem_valid   = mem_hold_q || pend_found;
    assign mem_idx     = mem_hold_q ? mem_hold_idx_q : pend_idx;
    assign mem_fire    = mem_valid && bus.mem_req_ready_i;
    assign ret_valid   = ret_hold_q || done_found;
    assign ret_idx     = ret_hold_q ? ret_hold_idx_q : done_idx;
    assign ret_fire    = ret_valid && bus.retire_ready_i;

    // Next state: each event targets an entry in a distinct state, so they never collide.
    always_comb begin
        state_d        = state_q;
        ent_d          = ent_q;
        mem_hold_d     = mem_valid && !bus.mem_req_ready_i;
        mem_hold_idx_d = mem_idx;
        ret_hold_d     = ret_valid && !bus.retire_ready_i;
        ret_hold_idx_d = ret_idx;
        if (alloc_fire) begin
            if (merge_hit) begin
                ent_d[merge_idx].be = ent_q[merge_idx].be | bus.alloc_be_i;
                for (int unsigned b = 0; b < 8; b++) begin
                    if (bus.alloc_be_i[b])
                        ent_d[merge_idx].wdata[8*b +: 8] = bus.alloc_wdata_i[8*b +: 8];
                end
            end else begin
                state_d[free_idx] = PENDING;
                ent_d[free_idx]   = '{id:    bus.alloc_id_i,
                                      addr:  bus.alloc_addr_i,
                                      we:    bus.alloc_we_i,
                                      wdata: bus.alloc_wdata_i,
                                      be:    bus.alloc_be_i};
            end
        end
        if (mem_fire)
            state_d[mem_idx] = INFLIGHT;
        if (bus.fill_valid_i && 32'(bus.fill_idx_i) < NR_ENTRIES &&
            state_q[bus.fill_idx_i] == INFLIGHT)
            state_d[bus.fill_idx_i] = DONE;
        if (ret_fire) begin
            state_d[ret_idx] = FREE;
            ent_d[ret_idx]   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                state_q[i] <= FREE;
                ent_q[i]   <= '0;
            end
            mem_hold_q     <= 1'b0;
            mem_hold_idx_q <= '0;
            ret_hold_q     <= 1'b0;
            ret_hold_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            ent_q          <= ent_d;
            mem_hold_q     <= mem_hold_d;
            mem_hold_idx_q <= mem_hold_idx_d;
            ret_hold_q     <= ret_hold_d;
            ret_hold_idx_q <= ret_hold_idx_d;
        end
    end

    assign bus.alloc_ready_o   = alloc_ready;
    assign bus.alloc_idx_o     = alloc_idx;
    assign bus.lookup_hit_o    = lookup_hit;
    assign bus.lookup_idx_o    = lookup_idx;
    assign bus.mem_req_valid_o = mem_valid;
    assign bus.mem_req_idx_o   = mem_valid ? mem_idx : '0;
    assign bus.mem_req_addr_o  = mem_valid ? {ent_q[mem_idx].addr[ADDR_WIDTH-1:LINE_OFFSET],
                                              {LINE_OFFSET{1'b0}}} : '0;
    assign bus.retire_valid_o  = ret_valid;
    assign bus.retire_idx_o    = ret_valid ? ret_idx : '0;
    assign bus.retire_id_o     = ret_valid ? ent_q[ret_idx].id : '0;
    assign bus.retire_addr_o   = ret_valid ? ent_q[ret_idx].addr : '0;
    assign bus.retire_we_o     = ret_valid ? ent_q[ret_idx].we : 1'b0;
    assign bus.retire_wdata_o  = ret_valid ? ent_q[ret_idx].wdata : '0;
    assign bus.retire_be_o     = ret_valid ? ent_q[ret_idx].be : '0;
    assign bus.full_o          = !free_found;
    assign bus.busy_o          = busy;

    assign unused_lookup_offset = ^bus.lookup_addr_i[LINE_OFFSET-1:0];
endmodule
